idt_clk_prog_ctrl: RTL and testbench



---
 rtl/idt_clk_prog_ctrl.sv | 170 +++++++++++++++++
 tb/tb_idt_clk_prog_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/idt_clk_prog_ctrl.sv
// Purpose : serially loads the IDT clock synthesizer's 24-bit config word (sclk/data/strobe), then waits PLL settle and flags lock.
// Latency : accept (or START exit) to done = 50*CLK_DIV + LOCK_WAIT + 1 osc_clk cycles.
// Backpressure: cfg_ready low while busy; requests are not queued, the requester holds cfg_valid until accepted.
module idt_clk_prog_ctrl #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned LOCK_WAIT   = 1000,
    parameter logic [23:0] DEFAULT_CFG = 24'h01_3808,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic        osc_clk,
    input  logic        osc_reset,
    input  logic        cfg_valid,
    input  logic [23:0] cfg_data,
    output logic        cfg_ready,
    output logic        busy,
    output logic        done,
    output logic        locked,
    output logic        idt_sclk,
    output logic        idt_data,
    output logic        idt_strobe
);

    typedef enum logic [2:0] {
        START,
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        GAP,
        STROBE,
        SETTLE
    } state_t;

    localparam state_t      RST_STATE   = AUTO_START ? START : IDLE;
    // Phase counter counts down to zero, so loading CLK_DIV-1 gives CLK_DIV cycles per phase.
    localparam logic [7:0]  PHASE_LOAD  = 8'(CLK_DIV - 1);
    // Settle counter runs LOCK_WAIT..0; the extra cycle is the hand-off into IDLE where done fires.
    localparam logic [19:0] SETTLE_LOAD = 20'(LOCK_WAIT);

    state_t      state_q, state_d;
    logic [23:0] shift_q, shift_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  phase_q, phase_d;
    logic [19:0] settle_q, settle_d;

    logic        done_d, locked_d, ready_d, busy_d;
    logic        sclk_d, data_d, strobe_d;

    // Next-state, datapath and next-output decode; outputs are computed from the next state so the registered pins line up with the state register.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        phase_d  = phase_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        locked_d = locked;

        unique case (state_q)
            START: begin
                shift_d = DEFAULT_CFG;
                idx_d   = 5'd23;
                phase_d = PHASE_LOAD;
                state_d = SHIFT_LO;
            end
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    shift_d  = cfg_data;
                    idx_d    = 5'd23;
                    phase_d  = PHASE_LOAD;
                    locked_d = 1'b0;
                    state_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_q == 8'd0) begin
                    phase_d = PHASE_LOAD;
                    state_d = SHIFT_HI;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            SHIFT_HI: begin
                if (phase_q == 8'd0) begin
                    phase_d = PHASE_LOAD;
                    if (idx_q == 5'd0) begin
                        state_d = GAP;
                    end else begin
                        idx_d   = idx_q - 5'd1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            GAP: begin
                if (phase_q == 8'd0) begin
                    phase_d = PHASE_LOAD;
                    state_d = STROBE;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            STROBE: begin
                if (phase_q == 8'd0) begin
                    settle_d = SETTLE_LOAD;
                    state_d  = SETTLE;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            SETTLE: begin
                if (settle_q == 20'd0) begin
                    done_d   = 1'b1;
                    locked_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    settle_d = settle_q - 20'd1;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase

        sclk_d   = (state_d == SHIFT_HI);
        data_d   = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shift_d[idx_d] : 1'b0;
        strobe_d = (state_d == STROBE);
        busy_d   = (state_d != IDLE);
        ready_d  = (state_d == IDLE);
    end

    // State and datapath registers; reset abandons any sequence in flight.
    always_ff @(posedge osc_clk or posedge osc_reset) begin
        if (osc_reset) begin
            state_q  <= RST_STATE;
            shift_q  <= '0;
            idx_q    <= '0;
            phase_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            settle_q <= settle_d;
        end
    end

    // Output registers; reset drops every pin at once so no partial strobe can reach the synthesizer.
    always_ff @(posedge osc_clk or posedge osc_reset) begin
        if (osc_reset) begin
            cfg_ready  <= ~AUTO_START;
            busy       <= 1'b0;
            done       <= 1'b0;
            locked     <= 1'b0;
            idt_sclk   <= 1'b0;
            idt_data   <= 1'b0;
            idt_strobe <= 1'b0;
        end else begin
            cfg_ready  <= ready_d;
            busy       <= busy_d;
            done       <= done_d;
            locked     <= locked_d;
            idt_sclk   <= sclk_d;
            idt_data   <= data_d;
            idt_strobe <= strobe_d;
        end
    end

endmodule

// File: tb/tb_idt_clk_prog_ctrl.sv
// Directed bench for idt_clk_prog_ctrl: instance A auto-starts (CLK_DIV=2, LOCK_WAIT=16),
// instance B waits for requests (CLK_DIV=1, LOCK_WAIT=1). Outputs sampled on the falling edge.
module tb_idt_clk_prog_ctrl;

    logic        osc_clk;
    logic        rst_a, rst_b;
    logic        cfg_valid_a, cfg_valid_b;
    logic [23:0] cfg_data_a, cfg_data_b;
    logic        cfg_ready_a, busy_a, done_a, locked_a, sclk_a, data_a, strobe_a;
    logic        cfg_ready_b, busy_b, done_b, locked_b, sclk_b, data_b, strobe_b;

    int vectors = 0;
    int miscompares = 0;

    // selects which instance the capture task observes and drives
    logic sel_b = 1'b0;
    wire  m_sclk   = sel_b ? sclk_b      : sclk_a;
    wire  m_data   = sel_b ? data_b      : data_a;
    wire  m_strobe = sel_b ? strobe_b    : strobe_a;
    wire  m_done   = sel_b ? done_b      : done_a;
    wire  m_locked = sel_b ? locked_b    : locked_a;
    wire  m_busy   = sel_b ? busy_b      : busy_a;
    wire  m_ready  = sel_b ? cfg_ready_b : cfg_ready_a;

    // results of the most recent capture; k counts rising edges since the reference edge
    logic [23:0] cap_word;
    int rise_cnt, first_rise, last_rise, bad_period;
    int strobe_cnt, strobe_first, last_fall, done_k, ready_early;
    logic locked_k0, busy_k0, locked_done, ready_done;

    idt_clk_prog_ctrl #(
        .CLK_DIV(2), .LOCK_WAIT(16), .DEFAULT_CFG(24'h01_3808), .AUTO_START(1'b1)
    ) dut_a (
        .osc_clk(osc_clk), .osc_reset(rst_a), .cfg_valid(cfg_valid_a), .cfg_data(cfg_data_a),
        .cfg_ready(cfg_ready_a), .busy(busy_a), .done(done_a), .locked(locked_a),
        .idt_sclk(sclk_a), .idt_data(data_a), .idt_strobe(strobe_a)
    );

    idt_clk_prog_ctrl #(
        .CLK_DIV(1), .LOCK_WAIT(1), .DEFAULT_CFG(24'h01_3808), .AUTO_START(1'b0)
    ) dut_b (
        .osc_clk(osc_clk), .osc_reset(rst_b), .cfg_valid(cfg_valid_b), .cfg_data(cfg_data_b),
        .cfg_ready(cfg_ready_b), .busy(busy_b), .done(done_b), .locked(locked_b),
        .idt_sclk(sclk_b), .idt_data(data_b), .idt_strobe(strobe_b)
    );

    initial osc_clk = 1'b0;
    always #5 osc_clk = ~osc_clk;

    task automatic drive(input logic v, input logic [23:0] d);
        if (sel_b) begin
            cfg_valid_b = v;
            cfg_data_b  = d;
        end else begin
            cfg_valid_a = v;
            cfg_data_a  = d;
        end
    endtask

    // Watches one sequence from the next rising edge until done (bounded). With hold=1 the
    // request stays asserted with junk data, switching to next_word on the done cycle.
    task automatic capture(input bit hold, input logic [23:0] next_word, input int period);
        logic prev;
        cap_word = '0; rise_cnt = 0; first_rise = -1; last_rise = -1; bad_period = 0;
        strobe_cnt = 0; strobe_first = -1; last_fall = -1; done_k = -1; ready_early = 0;
        locked_k0 = 1'bx; busy_k0 = 1'bx; locked_done = 1'bx; ready_done = 1'bx;
        prev = m_sclk;
        for (int k = 0; k < 400 && done_k < 0; k++) begin
            @(negedge osc_clk);
            if (k == 0) begin
                locked_k0 = m_locked;
                busy_k0   = m_busy;
            end
            if (m_sclk && !prev) begin
                rise_cnt++;
                cap_word = {cap_word[22:0], m_data};
                if (first_rise >= 0 && (k - last_rise) != period) bad_period++;
                if (first_rise < 0) first_rise = k;
                last_rise = k;
            end
            if (!m_sclk && prev) last_fall = k;
            prev = m_sclk;
            if (m_strobe) begin
                strobe_cnt++;
                if (strobe_first < 0) strobe_first = k;
            end
            if (m_done) begin
                done_k      = k;
                locked_done = m_locked;
                ready_done  = m_ready;
            end else if (m_ready) begin
                ready_early++;
            end
            if (hold) drive(1'b1, m_done ? next_word : 24'($urandom));
            else      drive(1'b0, 24'h0);
        end
    endtask

    task automatic test_reset();
        @(negedge osc_clk);
        vectors++; if ({sclk_a, data_a, strobe_a, busy_a, done_a, locked_a, cfg_ready_a} !== 7'b0) begin miscompares++; $display("FAIL reset_a outs got=%b exp=0000000", {sclk_a, data_a, strobe_a, busy_a, done_a, locked_a, cfg_ready_a}); end
        vectors++; if ({sclk_b, data_b, strobe_b, busy_b, done_b, locked_b} !== 6'b0) begin miscompares++; $display("FAIL reset_b outs got=%b exp=000000", {sclk_b, data_b, strobe_b, busy_b, done_b, locked_b}); end
        vectors++; if (cfg_ready_b !== 1'b1) begin miscompares++; $display("FAIL reset_b cfg_ready got=%b exp=1", cfg_ready_b); end
    endtask

    task automatic test_auto_start();
        sel_b = 1'b0;
        @(negedge osc_clk);
        rst_a = 1'b0;
        capture(1'b0, 24'h0, 4);
        vectors++; if (busy_k0 !== 1'b1) begin miscompares++; $display("FAIL auto busy got=%b exp=1", busy_k0); end
        vectors++; if (rise_cnt !== 24) begin miscompares++; $display("FAIL auto rises got=%0d exp=24", rise_cnt); end
        vectors++; if (cap_word !== 24'h01_3808) begin miscompares++; $display("FAIL auto word got=%h exp=013808", cap_word); end
        vectors++; if (first_rise !== 2 || bad_period !== 0) begin miscompares++; $display("FAIL auto sclk timing first=%0d badper=%0d exp 2/0", first_rise, bad_period); end
        vectors++; if (last_fall !== 96 || strobe_first !== 98 || strobe_cnt !== 2) begin miscompares++; $display("FAIL auto strobe fall=%0d first=%0d len=%0d exp 96/98/2", last_fall, strobe_first, strobe_cnt); end
        vectors++; if (done_k !== 117) begin miscompares++; $display("FAIL auto done_cycle got=%0d exp=117", done_k); end
        vectors++; if (locked_k0 !== 1'b0 || locked_done !== 1'b1 || ready_done !== 1'b1) begin miscompares++; $display("FAIL auto locked/ready lk0=%b lkdone=%b rdy=%b exp 0/1/1", locked_k0, locked_done, ready_done); end
    endtask

    task automatic test_request();
        sel_b = 1'b0;
        @(negedge osc_clk);
        drive(1'b1, 24'hA5_5A3C);
        capture(1'b0, 24'h0, 4);
        vectors++; if (cap_word !== 24'hA5_5A3C || rise_cnt !== 24) begin miscompares++; $display("FAIL req word got=%h rises=%0d exp=a55a3c/24", cap_word, rise_cnt); end
        vectors++; if (locked_k0 !== 1'b0) begin miscompares++; $display("FAIL req locked_drop got=%b exp=0", locked_k0); end
        vectors++; if (done_k !== 117 || locked_done !== 1'b1) begin miscompares++; $display("FAIL req done got=%0d locked=%b exp=117/1", done_k, locked_done); end
        @(negedge osc_clk);
        vectors++; if ({done_a, locked_a, cfg_ready_a, busy_a} !== 4'b0110) begin miscompares++; $display("FAIL req after_done {done,locked,ready,busy} got=%b exp=0110", {done_a, locked_a, cfg_ready_a, busy_a}); end
    endtask

    task automatic test_back_to_back();
        sel_b = 1'b0;
        @(negedge osc_clk);
        drive(1'b1, 24'h3C_96E1);
        capture(1'b1, 24'hC3_0F5A, 4);
        vectors++; if (cap_word !== 24'h3C_96E1) begin miscompares++; $display("FAIL b2b word1 got=%h exp=3c96e1", cap_word); end
        vectors++; if (ready_early !== 0 || ready_done !== 1'b1) begin miscompares++; $display("FAIL b2b ready busy_cycles_high=%0d at_done=%b exp 0/1", ready_early, ready_done); end
        vectors++; if (done_k !== 117) begin miscompares++; $display("FAIL b2b done1 got=%0d exp=117", done_k); end
        capture(1'b0, 24'h0, 4);
        vectors++; if (cap_word !== 24'hC3_0F5A || first_rise !== 2) begin miscompares++; $display("FAIL b2b word2 got=%h first=%0d exp=c30f5a/2", cap_word, first_rise); end
        vectors++; if (locked_k0 !== 1'b0 || done_k !== 117) begin miscompares++; $display("FAIL b2b accept2 locked=%b done=%0d exp 0/117", locked_k0, done_k); end
    endtask

    task automatic test_reset_abort();
        int strobe_seen;
        sel_b = 1'b0;
        strobe_seen = 0;
        @(negedge osc_clk);
        drive(1'b1, 24'hFF_FFFF);
        for (int k = 0; k <= 54; k++) begin
            @(negedge osc_clk);
            if (k == 0) drive(1'b0, 24'h0);
            if (strobe_a) strobe_seen++;
        end
        vectors++; if ({sclk_a, data_a, busy_a} !== 3'b111) begin miscompares++; $display("FAIL abort bit10_high {sclk,data,busy} got=%b exp=111", {sclk_a, data_a, busy_a}); end
        rst_a = 1'b1;
        #1;
        vectors++; if ({sclk_a, data_a, strobe_a, busy_a, locked_a, cfg_ready_a} !== 6'b0) begin miscompares++; $display("FAIL abort async_clear got=%b exp=000000", {sclk_a, data_a, strobe_a, busy_a, locked_a, cfg_ready_a}); end
        repeat (3) begin
            @(negedge osc_clk);
            if (strobe_a) strobe_seen++;
        end
        vectors++; if (strobe_seen !== 0) begin miscompares++; $display("FAIL abort strobe_cycles got=%0d exp=0", strobe_seen); end
        rst_a = 1'b0;
        capture(1'b0, 24'h0, 4);
        vectors++; if (cap_word !== 24'h01_3808 || rise_cnt !== 24 || first_rise !== 2) begin miscompares++; $display("FAIL abort restart word=%h rises=%0d first=%0d exp 013808/24/2", cap_word, rise_cnt, first_rise); end
        vectors++; if (strobe_cnt !== 2 || done_k !== 117) begin miscompares++; $display("FAIL abort restart strobe=%0d done=%0d exp 2/117", strobe_cnt, done_k); end
    endtask

    task automatic test_no_auto();
        int sclk_seen;
        sel_b = 1'b1;
        sclk_seen = 0;
        @(negedge osc_clk);
        rst_b = 1'b0;
        repeat (8) begin
            @(negedge osc_clk);
            if (sclk_b || busy_b) sclk_seen++;
        end
        vectors++; if (sclk_seen !== 0 || cfg_ready_b !== 1'b1) begin miscompares++; $display("FAIL noauto idle active_cycles=%0d ready=%b exp 0/1", sclk_seen, cfg_ready_b); end
        drive(1'b1, 24'h5A_C3E1);
        capture(1'b0, 24'h0, 2);
        vectors++; if (cap_word !== 24'h5A_C3E1 || rise_cnt !== 24) begin miscompares++; $display("FAIL noauto word got=%h rises=%0d exp=5ac3e1/24", cap_word, rise_cnt); end
        vectors++; if (first_rise !== 1 || bad_period !== 0) begin miscompares++; $display("FAIL noauto sclk first=%0d badper=%0d exp 1/0", first_rise, bad_period); end
        vectors++; if (strobe_first !== 49 || strobe_cnt !== 1) begin miscompares++; $display("FAIL noauto strobe first=%0d len=%0d exp 49/1", strobe_first, strobe_cnt); end
        vectors++; if (done_k !== 52 || locked_done !== 1'b1) begin miscompares++; $display("FAIL noauto done got=%0d locked=%b exp 52/1", done_k, locked_done); end
        sel_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        cfg_valid_a = 1'b0; cfg_data_a = '0;
        cfg_valid_b = 1'b0; cfg_data_b = '0;
        test_reset();
        test_auto_start();
        test_request();
        test_back_to_back();
        test_reset_abort();
        test_no_auto();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
